sdram_arbiter_mc: RTL and testbench

//  Multi-channel SDRAM command arbiter/pin mux. Sequences init, then arbitrates

---
 rtl/sdram_arbiter_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_arbiter_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_mc.sv
// rtl/sdram_arbiter_mc.sv - SDRAM init/refresh/client arbiter with registered pin mux
// Optional: define SDRAM_ARB_RESUME_EN to resume the yielding channel straight after refresh.
module sdram_arbiter_mc #(
    parameter int NUM_CH = 2,
    parameter int DQ_W   = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQM_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_done,
    input  logic [3:0]               init_cmd,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic                     aref_req,
    input  logic [3:0]               aref_cmd,
    input  logic [ADDR_W-1:0]        aref_addr,
    input  logic                     aref_end,
    output logic                     aref_en,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_aref_pend,
    input  logic [NUM_CH-1:0]        ch_end,
    input  logic [NUM_CH-1:0]        ch_yield,
    input  logic [4*NUM_CH-1:0]      ch_cmd,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [BA_W*NUM_CH-1:0]   ch_bank,
    input  logic [DQM_W*NUM_CH-1:0]  ch_dqm,
    input  logic [DQ_W*NUM_CH-1:0]   ch_wdata,
    input  logic [NUM_CH-1:0]        ch_wdata_oe,
    output logic [3:0]               sdram_cmd,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [BA_W-1:0]          sdram_ba,
    output logic [DQM_W-1:0]         sdram_dqm,
    output logic [DQ_W-1:0]          sdram_dq_o,
    output logic                     sdram_dq_oe
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [1:0] {ST_INIT, ST_ARB, ST_AREF, ST_CH} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;
    logic [SEL_W-1:0] rr_ptr, rr_nxt;
`ifdef SDRAM_ARB_RESUME_EN
    logic             resume, resume_nxt;
`endif

    logic             found;
    logic [SEL_W-1:0] pick;

    logic [3:0]        c_cmd;
    logic [ADDR_W-1:0] c_addr;
    logic [BA_W-1:0]   c_bank;
    logic [DQM_W-1:0]  c_dqm;
    logic [DQ_W-1:0]   c_wdata;
    logic              c_oe, c_end, c_yield;

    logic [3:0]        cmd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BA_W-1:0]   ba_nxt;
    logic [DQM_W-1:0]  dqm_nxt;
    logic [DQ_W-1:0]   dq_nxt;
    logic              oe_nxt;

    // Round-robin scan starting just after the last channel that finished.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!found && ch_req[idx]) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        c_cmd   = CMD_NOP;
        c_addr  = '0;
        c_bank  = '0;
        c_dqm   = '1;
        c_wdata = '0;
        c_oe    = 1'b0;
        c_end   = 1'b0;
        c_yield = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                c_cmd   = ch_cmd[4*i +: 4];
                c_addr  = ch_addr[ADDR_W*i +: ADDR_W];
                c_bank  = ch_bank[BA_W*i +: BA_W];
                c_dqm   = ch_dqm[DQM_W*i +: DQM_W];
                c_wdata = ch_wdata[DQ_W*i +: DQ_W];
                c_oe    = ch_wdata_oe[i];
                c_end   = ch_end[i];
                c_yield = ch_yield[i];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_nxt     = rr_ptr;
`ifdef SDRAM_ARB_RESUME_EN
        resume_nxt = resume;
`endif
        case (state)
            ST_INIT: if (init_done) state_nxt = ST_ARB;
            ST_ARB: begin
                if (aref_req) begin
                    state_nxt  = ST_AREF;
`ifdef SDRAM_ARB_RESUME_EN
                    resume_nxt = 1'b0;
`endif
                end else if (found) begin
                    state_nxt = ST_CH;
                    sel_nxt   = pick;
                end
            end
            ST_AREF: begin
                if (aref_end) begin
`ifdef SDRAM_ARB_RESUME_EN
                    state_nxt  = resume ? ST_CH : ST_ARB;
                    resume_nxt = 1'b0;
`else
                    state_nxt  = ST_ARB;
`endif
                end
            end
            ST_CH: begin
                // End beats yield: the refresh is then picked up from ARB.
                if (c_end) begin
                    state_nxt = ST_ARB;
                    rr_nxt    = sel;
                end else if (c_yield) begin
                    state_nxt  = ST_AREF;
`ifdef SDRAM_ARB_RESUME_EN
                    resume_nxt = 1'b1;
`endif
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        cmd_nxt  = CMD_NOP;
        addr_nxt = sdram_addr;
        ba_nxt   = sdram_ba;
        dqm_nxt  = sdram_dqm;
        dq_nxt   = sdram_dq_o;
        oe_nxt   = 1'b0;
        case (state)
            ST_INIT: begin
                cmd_nxt  = init_cmd;
                addr_nxt = init_addr;
            end
            ST_AREF: begin
                cmd_nxt  = aref_cmd;
                addr_nxt = aref_addr;
                ba_nxt   = '0;
                dqm_nxt  = '0;
            end
            ST_CH: begin
                cmd_nxt  = c_cmd;
                addr_nxt = c_addr;
                ba_nxt   = c_bank;
                dqm_nxt  = c_dqm;
                dq_nxt   = c_wdata;
                oe_nxt   = c_oe;
            end
            default: cmd_nxt = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            sel         <= '0;
            rr_ptr      <= SEL_W'(NUM_CH - 1);
`ifdef SDRAM_ARB_RESUME_EN
            resume      <= 1'b0;
`endif
            sdram_cmd   <= CMD_NOP;
            sdram_addr  <= '0;
            sdram_ba    <= '0;
            sdram_dqm   <= '1;
            sdram_dq_o  <= '0;
            sdram_dq_oe <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            rr_ptr      <= rr_nxt;
`ifdef SDRAM_ARB_RESUME_EN
            resume      <= resume_nxt;
`endif
            sdram_cmd   <= cmd_nxt;
            sdram_addr  <= addr_nxt;
            sdram_ba    <= ba_nxt;
            sdram_dqm   <= dqm_nxt;
            sdram_dq_o  <= dq_nxt;
            sdram_dq_oe <= oe_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_gnt[i] = (state == ST_CH) && (sel == SEL_W'(i));
        end
    end

    assign ch_aref_pend = {NUM_CH{aref_req}} & ch_gnt;
    assign aref_en      = (state == ST_AREF);

endmodule

// File: tb/tb_sdram_arbiter_mc.sv
// tb/tb_sdram_arbiter_mc.sv - ownership-model bench for sdram_arbiter_mc
module tb_sdram_arbiter_mc;

    localparam int N = 2, DW = 16, AW = 13, BW = 2, MW = 2;
    localparam int OWN_INIT = -2, OWN_IDLE = -1, OWN_REF = 99;

    logic clk = 1'b0, rst_n;
    logic init_done, aref_req, aref_end, aref_en;
    logic [3:0] init_cmd, aref_cmd;
    logic [AW-1:0] init_addr, aref_addr;
    logic [N-1:0] ch_req, ch_gnt, ch_aref_pend, ch_end, ch_yield, ch_wdata_oe;
    logic [4*N-1:0] ch_cmd;
    logic [AW*N-1:0] ch_addr;
    logic [BW*N-1:0] ch_bank;
    logic [MW*N-1:0] ch_dqm;
    logic [DW*N-1:0] ch_wdata;
    logic [3:0] sdram_cmd;
    logic [AW-1:0] sdram_addr;
    logic [BW-1:0] sdram_ba;
    logic [MW-1:0] sdram_dqm;
    logic [DW-1:0] sdram_dq_o;
    logic sdram_dq_oe;

    int n_chk = 0, n_fail = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sdram_arbiter_mc #(.NUM_CH(N), .DQ_W(DW), .ADDR_W(AW), .BA_W(BW), .DQM_W(MW)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .init_cmd(init_cmd),
        .init_addr(init_addr), .aref_req(aref_req), .aref_cmd(aref_cmd),
        .aref_addr(aref_addr), .aref_end(aref_end), .aref_en(aref_en),
        .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_aref_pend(ch_aref_pend),
        .ch_end(ch_end), .ch_yield(ch_yield), .ch_cmd(ch_cmd), .ch_addr(ch_addr),
        .ch_bank(ch_bank), .ch_dqm(ch_dqm), .ch_wdata(ch_wdata),
        .ch_wdata_oe(ch_wdata_oe), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm), .sdram_dq_o(sdram_dq_o),
        .sdram_dq_oe(sdram_dq_oe)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the pins (init, nobody, refresh, or a channel number).
    int m_own, m_last, m_resume_ch;
    bit m_resume;
    logic [3:0] e_cmd;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_ba;
    logic [MW-1:0] e_dqm;
    logic [DW-1:0] e_dq;
    logic e_oe;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = OWN_INIT; m_last = N - 1; m_resume = 1'b0; m_resume_ch = 0;
            e_cmd = 4'b0111; e_addr = '0; e_ba = '0; e_dqm = '1; e_dq = '0; e_oe = 1'b0;
        end else begin
            e_oe = 1'b0;
            if (m_own == OWN_INIT) begin
                e_cmd = init_cmd; e_addr = init_addr;
            end else if (m_own == OWN_IDLE) begin
                e_cmd = 4'b0111;
            end else if (m_own == OWN_REF) begin
                e_cmd = aref_cmd; e_addr = aref_addr; e_ba = '0; e_dqm = '0;
            end else begin
                e_cmd = ch_cmd[4*m_own +: 4];
                e_addr = ch_addr[AW*m_own +: AW];
                e_ba = ch_bank[BW*m_own +: BW];
                e_dqm = ch_dqm[MW*m_own +: MW];
                e_dq = ch_wdata[DW*m_own +: DW];
                e_oe = ch_wdata_oe[m_own];
            end
            if (m_own == OWN_INIT) begin
                if (init_done) m_own = OWN_IDLE;
            end else if (m_own == OWN_IDLE) begin
                if (aref_req) begin
                    m_own = OWN_REF; m_resume = 1'b0;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        if (m_own == OWN_IDLE && ch_req[(m_last + k) % N]) m_own = (m_last + k) % N;
                    end
                end
            end else if (m_own == OWN_REF) begin
                if (aref_end) begin
`ifdef SDRAM_ARB_RESUME_EN
                    m_own = m_resume ? m_resume_ch : OWN_IDLE;
`else
                    m_own = OWN_IDLE;
`endif
                    m_resume = 1'b0;
                end
            end else if (ch_end[m_own]) begin
                m_last = m_own; m_own = OWN_IDLE;
            end else if (ch_yield[m_own]) begin
                m_resume = 1'b1; m_resume_ch = m_own; m_own = OWN_REF;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N-1:0] eg;
            eg = '0;
            if (m_own >= 0 && m_own < N) eg[m_own] = 1'b1;
            chk("m_gnt", 32'(ch_gnt), 32'(eg));
            chk("m_pend", 32'(ch_aref_pend), 32'(aref_req ? eg : '0));
            chk("m_aref_en", 32'(aref_en), 32'(m_own == OWN_REF));
            chk("m_cmd", 32'(sdram_cmd), 32'(e_cmd));
            chk("m_addr", 32'(sdram_addr), 32'(e_addr));
            chk("m_ba", 32'(sdram_ba), 32'(e_ba));
            chk("m_dqm", 32'(sdram_dqm), 32'(e_dqm));
            chk("m_dq", 32'(sdram_dq_o), 32'(e_dq));
            chk("m_oe", 32'(sdram_dq_oe), 32'(e_oe));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int w;
        rst_n = 1'b0; init_done = 1'b0; init_cmd = 4'b0010; init_addr = '0;
        aref_req = 1'b0; aref_cmd = 4'b0001; aref_addr = 13'h400; aref_end = 1'b0;
        ch_req = '0; ch_end = '0; ch_yield = '0; ch_cmd = 8'h77; ch_addr = '0;
        ch_bank = '0; ch_dqm = '0; ch_wdata = '0; ch_wdata_oe = '0;
        cmp_en = 1'b1;
        step();
        chk("rst_cmd", 32'(sdram_cmd), 32'h7);
        chk("rst_gnt", 32'(ch_gnt), 32'h0);
        chk("rst_dqm", 32'(sdram_dqm), 32'h3);
        chk("rst_oe", 32'(sdram_dq_oe), 32'h0);
        rst_n = 1'b1;
        step();
        chk("init_cmd", 32'(sdram_cmd), 32'h2);
        init_done = 1'b1;
        step(); step();
        chk("arb_nop", 32'(sdram_cmd), 32'h7);

        // refresh beats a simultaneous channel request
        aref_req = 1'b1; ch_req = 2'b01;
        step();
        chk("pri_aref_en", 32'(aref_en), 32'h1);
        chk("pri_gnt0", 32'(ch_gnt), 32'h0);
        aref_req = 1'b0;
        step();
        chk("pri_gnt1", 32'(ch_gnt), 32'h0);
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        chk("pri_gnt2", 32'(ch_gnt), 32'h0);
        step();
        chk("pri_gnt_ch0", 32'(ch_gnt), 32'h1);

        // write path
        ch_cmd = 8'h74; ch_wdata = 32'h0000A5C3; ch_wdata_oe = 2'b01;
        step();
        chk("wr_cmd", 32'(sdram_cmd), 32'h4);
        chk("wr_dq", 32'(sdram_dq_o), 32'hA5C3);
        chk("wr_oe", 32'(sdram_dq_oe), 32'h1);
        ch_end = 2'b01; ch_req = 2'b00;
        step();
        ch_end = 2'b00;
        step();
        chk("arb_oe", 32'(sdram_dq_oe), 32'h0);
        chk("arb_cmd", 32'(sdram_cmd), 32'h7);
        ch_wdata_oe = 2'b00; ch_cmd = 8'h77;

        // yield for refresh
        ch_req = 2'b10;
        step();
        chk("y_gnt", 32'(ch_gnt), 32'h2);
        aref_req = 1'b1;
        #1 chk("y_pend", 32'(ch_aref_pend), 32'h2);
        step();
        chk("y_no_aref", 32'(aref_en), 32'h0);
        chk("y_hold_gnt", 32'(ch_gnt), 32'h2);
        ch_yield = 2'b10;
        step();
        ch_yield = 2'b00; aref_req = 1'b0; ch_req = 2'b00;
        chk("y_aref_en", 32'(aref_en), 32'h1);
        chk("y_gnt_off", 32'(ch_gnt), 32'h0);
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
`ifdef SDRAM_ARB_RESUME_EN
        chk("y_resume", 32'(ch_gnt), 32'h2);
`else
        chk("y_via_arb", 32'(ch_gnt), 32'h0);
        ch_req = 2'b10;
        step();
        chk("y_regrant", 32'(ch_gnt), 32'h2);
`endif
        ch_end = 2'b10;
        step();
        ch_end = 2'b00; ch_req = 2'b01;
        step();
        chk("mb_gnt", 32'(ch_gnt), 32'h1);
        ch_cmd = 8'h74; ch_wdata_oe = 2'b01;
        step();
        chk("mb_oe", 32'(sdram_dq_oe), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mb_rst_gnt", 32'(ch_gnt), 32'h0);
        chk("mb_rst_cmd", 32'(sdram_cmd), 32'h7);
        chk("mb_rst_oe", 32'(sdram_dq_oe), 32'h0);
        step();
        rst_n = 1'b1; ch_req = 2'b00; ch_wdata_oe = 2'b00;
        step(); step();

        // round robin with both channels requesting
        ch_req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            while (ch_gnt == '0 && w < 20) begin
                step();
                w++;
            end
            chk("rr_wait", 32'(w < 20), 32'h1);
            chk("rr_gnt", 32'(ch_gnt), (g % 2 == 0) ? 32'h1 : 32'h2);
            repeat (3) step();
            ch_end = ch_gnt;
            step();
            ch_end = 2'b00;
        end
        ch_req = 2'b00;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ch_req = 2'($urandom);
            aref_req = ($urandom_range(0, 7) == 0);
            aref_end = ($urandom_range(0, 4) == 0);
            ch_end = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
            ch_yield = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            ch_cmd = 8'($urandom); ch_addr = 26'($urandom); ch_bank = 4'($urandom);
            ch_dqm = 4'($urandom); ch_wdata = $urandom; ch_wdata_oe = 2'($urandom);
            init_cmd = 4'($urandom); init_addr = 13'($urandom);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            init_done = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
